// File: rtl/arcade_input_mapper_if.sv
// Input-mapper bundle: ps2/joystick/rotation inputs and per-player cabinet outputs.
// Pure wiring, no latency of its own.
// No backpressure: every signal is a level or a toggle-coded event.
interface arcade_input_mapper_if #(
    parameter int NUM_PLAYERS = 2
);
    logic [10:0]            ps2_key;
    logic [15:0]            joystick_0;
    logic [15:0]            joystick_1;
    logic                   no_rotate;
    logic [NUM_PLAYERS-1:0] p_up;
    logic [NUM_PLAYERS-1:0] p_down;
    logic [NUM_PLAYERS-1:0] p_left;
    logic [NUM_PLAYERS-1:0] p_right;
    logic [NUM_PLAYERS-1:0] p_fire;
    logic [1:0]             start;
    logic                   coin;

    // hps_io side drives the inputs and observes the cabinet outputs
    modport master (
        output ps2_key, joystick_0, joystick_1, no_rotate,
        input  p_up, p_down, p_left, p_right, p_fire, start, coin
    );

    // mapper side
    modport slave (
        input  ps2_key, joystick_0, joystick_1, no_rotate,
        output p_up, p_down, p_left, p_right, p_fire, start, coin
    );
endinterface

// File: rtl/arcade_input_mapper.sv
// Keyboard/joystick to cabinet input mapper with rotation remap, coin stretch, optional autofire.
// Latency: joystick -> output 1 edge, ps2 key event -> output 2 edges.
// No backpressure: inputs are sampled every cycle. Autofire built only with ARCADE_INPUT_AUTOFIRE_EN.
module arcade_input_mapper #(
    parameter int          NUM_PLAYERS       = 2,
    parameter int unsigned COIN_PULSE_CYCLES = 50000,
    parameter int unsigned AUTOFIRE_DIV      = 200000
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    arcade_input_mapper_if.slave  io
);

    localparam bit P2_FOLD = (NUM_PLAYERS == 1);
    localparam int CW      = (COIN_PULSE_CYCLES > 1) ? $clog2(COIN_PULSE_CYCLES) : 1;
    localparam logic [CW-1:0] COIN_LOAD = CW'(COIN_PULSE_CYCLES - 1);

    // Held-key register bit positions
    localparam int K_U1 = 0,  K_D1 = 1,  K_L1 = 2,  K_R1 = 3,  K_F1 = 4;
    localparam int K_S1 = 5,  K_S2 = 6,  K_COIN = 7;
    localparam int K_U2 = 8,  K_D2 = 9,  K_L2 = 10, K_R2 = 11, K_F2 = 12;

    logic [12:0] key_q, key_d;
    logic        old_toggle_q;

    // Decode a toggle-coded ps2 event into the held-key bit it addresses
    always_comb begin
        key_d = key_q;
        if (io.ps2_key[10] != old_toggle_q) begin
            // Arrows match with or without the E0 prefix; everything else is non-extended only
            case (io.ps2_key[8:0])
                9'h075, 9'h175: key_d[K_U1]   = io.ps2_key[9];
                9'h072, 9'h172: key_d[K_D1]   = io.ps2_key[9];
                9'h06B, 9'h16B: key_d[K_L1]   = io.ps2_key[9];
                9'h074, 9'h174: key_d[K_R1]   = io.ps2_key[9];
                9'h029, 9'h014: key_d[K_F1]   = io.ps2_key[9];
                9'h005, 9'h016: key_d[K_S1]   = io.ps2_key[9];
                9'h006, 9'h01E: key_d[K_S2]   = io.ps2_key[9];
                9'h02E, 9'h036: key_d[K_COIN] = io.ps2_key[9];
                9'h02D:         key_d[K_U2]   = io.ps2_key[9];
                9'h02B:         key_d[K_D2]   = io.ps2_key[9];
                9'h023:         key_d[K_L2]   = io.ps2_key[9];
                9'h034:         key_d[K_R2]   = io.ps2_key[9];
                9'h01C:         key_d[K_F2]   = io.ps2_key[9];
                default:        ;
            endcase
        end
    end

    // Key state; on reset the current toggle is absorbed so no stale event is decoded
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            key_q        <= '0;
            old_toggle_q <= io.ps2_key[10];
        end else begin
            key_q        <= key_d;
            old_toggle_q <= io.ps2_key[10];
        end
    end

    // Single-player cabinets take both joysticks on P1
    logic [8:0] jp1;
    assign jp1 = P2_FOLD ? (io.joystick_0[8:0] | io.joystick_1[8:0]) : io.joystick_0[8:0];

    logic [1:0] u_src, d_src, l_src, r_src, f_src, af_fire;

    // Per-player direction/fire sources: held keys ORed with joystick bits
    always_comb begin
        u_src[0] = key_q[K_U1] | (P2_FOLD & key_q[K_U2]) | jp1[3];
        d_src[0] = key_q[K_D1] | (P2_FOLD & key_q[K_D2]) | jp1[2];
        l_src[0] = key_q[K_L1] | (P2_FOLD & key_q[K_L2]) | jp1[1];
        r_src[0] = key_q[K_R1] | (P2_FOLD & key_q[K_R2]) | jp1[0];
        f_src[0] = key_q[K_F1] | (P2_FOLD & key_q[K_F2]) | jp1[4];
        u_src[1] = key_q[K_U2] | io.joystick_1[3];
        d_src[1] = key_q[K_D2] | io.joystick_1[2];
        l_src[1] = key_q[K_L2] | io.joystick_1[1];
        r_src[1] = key_q[K_R2] | io.joystick_1[0];
        f_src[1] = key_q[K_F2] | io.joystick_1[4];
    end

`ifdef ARCADE_INPUT_AUTOFIRE_EN
    localparam int AW = (AUTOFIRE_DIV > 1) ? $clog2(AUTOFIRE_DIV) : 1;
    localparam logic [AW-1:0] AF_LAST = AW'(AUTOFIRE_DIV - 1);

    logic [1:0]    af_hold;
    logic [AW-1:0] af_cnt_q   [2];
    logic [AW-1:0] af_cnt_d   [2];
    logic [1:0]    af_phase_q, af_phase_d;

    assign af_hold = {io.joystick_1[8], jp1[8]};

    // Square wave per player: high phase first, counter/phase held at zero while released
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            af_cnt_d[p]   = '0;
            af_phase_d[p] = 1'b0;
            af_fire[p]    = 1'b0;
            if (af_hold[p]) begin
                af_fire[p] = ~af_phase_q[p];
                if (af_cnt_q[p] == AF_LAST) begin
                    af_phase_d[p] = ~af_phase_q[p];
                end else begin
                    af_cnt_d[p]   = af_cnt_q[p] + AW'(1);
                    af_phase_d[p] = af_phase_q[p];
                end
            end
        end
    end

    // Autofire counter and phase state
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            af_cnt_q[0] <= '0;
            af_cnt_q[1] <= '0;
            af_phase_q  <= '0;
        end else begin
            af_cnt_q[0] <= af_cnt_d[0];
            af_cnt_q[1] <= af_cnt_d[1];
            af_phase_q  <= af_phase_d;
        end
    end
`else
    assign af_fire = 2'b00;
`endif

    logic [NUM_PLAYERS-1:0] up_q, down_q, left_q, right_q, fire_q;
    logic [NUM_PLAYERS-1:0] up_d, down_d, left_d, right_d, fire_d;
    logic [1:0]             start_q, start_d;

    // Rotation remap and output merge; rotation select is sampled like any other input
    always_comb begin
        up_d    = io.no_rotate ? l_src[NUM_PLAYERS-1:0] : u_src[NUM_PLAYERS-1:0];
        down_d  = io.no_rotate ? r_src[NUM_PLAYERS-1:0] : d_src[NUM_PLAYERS-1:0];
        left_d  = io.no_rotate ? d_src[NUM_PLAYERS-1:0] : l_src[NUM_PLAYERS-1:0];
        right_d = io.no_rotate ? u_src[NUM_PLAYERS-1:0] : r_src[NUM_PLAYERS-1:0];
        fire_d  = f_src[NUM_PLAYERS-1:0] | af_fire[NUM_PLAYERS-1:0];
        start_d = {key_q[K_S2] | io.joystick_0[6] | io.joystick_1[6],
                   key_q[K_S1] | io.joystick_0[5] | io.joystick_1[5]};
    end

    // Registered cabinet outputs
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            up_q    <= '0;
            down_q  <= '0;
            left_q  <= '0;
            right_q <= '0;
            fire_q  <= '0;
            start_q <= '0;
        end else begin
            up_q    <= up_d;
            down_q  <= down_d;
            left_q  <= left_d;
            right_q <= right_d;
            fire_q  <= fire_d;
            start_q <= start_d;
        end
    end

    // Coin stretcher
    typedef enum logic [1:0] {C_IDLE, C_PULSE, C_WAIT_REL} coin_state_t;

    coin_state_t state_q;
    logic [CW-1:0] coin_cnt_q;
    logic          coin_q;
    logic          coin_src_d, coin_src_q;

    assign coin_src_d = key_q[K_COIN] | io.joystick_0[7] | io.joystick_1[7];

    // Previous coin-source level for rising-edge detection
    always_ff @(posedge clk_sys) begin
        if (!reset_n) coin_src_q <= 1'b0;
        else          coin_src_q <= coin_src_d;
    end

    // Coin FSM: fixed-width pulse, then wait for every source to release before re-arming
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q    <= C_IDLE;
            coin_q     <= 1'b0;
            coin_cnt_q <= '0;
        end else begin
            case (state_q)
                C_IDLE: begin
                    if (coin_src_d && !coin_src_q) begin
                        state_q    <= C_PULSE;
                        coin_q     <= 1'b1;
                        coin_cnt_q <= COIN_LOAD;
                    end
                end
                C_PULSE: begin
                    if (coin_cnt_q == '0) begin
                        state_q <= C_WAIT_REL;
                        coin_q  <= 1'b0;
                    end else begin
                        coin_cnt_q <= coin_cnt_q - CW'(1);
                    end
                end
                C_WAIT_REL: begin
                    if (!coin_src_d) state_q <= C_IDLE;
                end
                default: begin
                    state_q <= C_IDLE;
                    coin_q  <= 1'b0;
                end
            endcase
        end
    end

    assign io.p_up    = up_q;
    assign io.p_down  = down_q;
    assign io.p_left  = left_q;
    assign io.p_right = right_q;
    assign io.p_fire  = fire_q;
    assign io.start   = start_q;
    assign io.coin    = coin_q;

    // Joystick bits beyond the mapped layout carry nothing for this block
    logic unused_bits;
    assign unused_bits = &{1'b0, io.joystick_0[15:8], io.joystick_1[15:8], jp1[8]};

endmodule

// File: tb/tb_arcade_input_mapper.sv
module tb_arcade_input_mapper;

    localparam int CP     = 4;
    localparam int AF_DIV = 3;

    logic        clk;
    logic        rst_n;
    logic [10:0] ps2;
    logic [15:0] j0, j1;
    logic        nr;

    int cmp_cnt = 0;
    int err_cnt = 0;
    bit chk_en  = 1'b1;

    arcade_input_mapper_if #(.NUM_PLAYERS(2)) bus2 ();
    arcade_input_mapper_if #(.NUM_PLAYERS(1)) bus1 ();

    assign bus2.ps2_key = ps2;  assign bus1.ps2_key = ps2;
    assign bus2.joystick_0 = j0; assign bus1.joystick_0 = j0;
    assign bus2.joystick_1 = j1; assign bus1.joystick_1 = j1;
    assign bus2.no_rotate = nr;  assign bus1.no_rotate = nr;

    arcade_input_mapper #(.NUM_PLAYERS(2), .COIN_PULSE_CYCLES(CP), .AUTOFIRE_DIV(AF_DIV)) dut (
        .clk_sys(clk), .reset_n(rst_n), .io(bus2));
    arcade_input_mapper #(.NUM_PLAYERS(1), .COIN_PULSE_CYCLES(CP), .AUTOFIRE_DIV(AF_DIV)) dut1 (
        .clk_sys(clk), .reset_n(rst_n), .io(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string nm, input int act, input int exp);
        cmp_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s @%0t: got %0d want %0d", nm, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Roles: 0..3 P1 U/D/L/R, 4 P1 fire, 5 start1, 6 start2, 7 coin, 8..11 P2 U/D/L/R, 12 P2 fire
    function automatic int role_of(input logic ext, input logic [7:0] c);
        case (c)
            8'h75: return 0;
            8'h72: return 1;
            8'h6B: return 2;
            8'h74: return 3;
            default: ;
        endcase
        if (ext) return -1;
        case (c)
            8'h29, 8'h14: return 4;
            8'h05, 8'h16: return 5;
            8'h06, 8'h1E: return 6;
            8'h2E, 8'h36: return 7;
            8'h2D: return 8;
            8'h2B: return 9;
            8'h23: return 10;
            8'h34: return 11;
            8'h1C: return 12;
            default: return -1;
        endcase
    endfunction

    // n = consecutive edges with autofire held; high for DIV, low for DIV, ...
    function automatic logic afon(input int n);
        logic r;
        r = (n > 0) && ((((n - 1) / AF_DIV) % 2) == 0);
`ifndef ARCADE_INPUT_AUTOFIRE_EN
        r = 1'b0;
`endif
        return r;
    endfunction

    // returns {up, down, left, right}
    function automatic logic [3:0] rot(input logic u, d, l, r, n);
        return n ? {l, r, d, u} : {u, d, l, r};
    endfunction

    bit   held [13];
    logic old_tog;
    int   n_a, n_b, n_or, c_rem;
    bit   c_wait, c_prev;
    logic [1:0] e2_up, e2_dn, e2_lf, e2_rt, e2_fi, e_st;
    logic e1_up, e1_dn, e1_lf, e1_rt, e1_fi, e_coin;

    always @(posedge clk) begin : model
        logic [3:0]  o;
        logic [15:0] jo;
        logic        src;
        int          k;
        if (!rst_n) begin
            for (int i = 0; i < 13; i++) held[i] = 1'b0;
            old_tog = ps2[10];
            n_a = 0; n_b = 0; n_or = 0; c_rem = 0; c_wait = 0; c_prev = 0;
            e2_up = 0; e2_dn = 0; e2_lf = 0; e2_rt = 0; e2_fi = 0; e_st = 0;
            e1_up = 0; e1_dn = 0; e1_lf = 0; e1_rt = 0; e1_fi = 0; e_coin = 0;
        end else begin
            jo   = j0 | j1;
            n_a  = j0[8] ? n_a + 1 : 0;
            n_b  = j1[8] ? n_b + 1 : 0;
            n_or = jo[8] ? n_or + 1 : 0;
            o = rot(held[0] | j0[3], held[1] | j0[2], held[2] | j0[1], held[3] | j0[0], nr);
            {e2_up[0], e2_dn[0], e2_lf[0], e2_rt[0]} = o;
            e2_fi[0] = held[4] | j0[4] | afon(n_a);
            o = rot(held[8] | j1[3], held[9] | j1[2], held[10] | j1[1], held[11] | j1[0], nr);
            {e2_up[1], e2_dn[1], e2_lf[1], e2_rt[1]} = o;
            e2_fi[1] = held[12] | j1[4] | afon(n_b);
            o = rot(held[0] | held[8] | jo[3], held[1] | held[9] | jo[2],
                    held[2] | held[10] | jo[1], held[3] | held[11] | jo[0], nr);
            {e1_up, e1_dn, e1_lf, e1_rt} = o;
            e1_fi = held[4] | held[12] | jo[4] | afon(n_or);
            e_st  = {held[6] | jo[6], held[5] | jo[5]};
            src = held[7] | jo[7];
            if (c_rem > 0) begin
                c_rem--;
                if (c_rem == 0) c_wait = 1'b1;
            end else if (c_wait) begin
                if (!src) c_wait = 1'b0;
            end else if (src && !c_prev) begin
                c_rem = CP;
            end
            c_prev = src;
            e_coin = (c_rem > 0);
            if (ps2[10] != old_tog) begin
                old_tog = ps2[10];
                k = role_of(ps2[8], ps2[7:0]);
                if (k >= 0) held[k] = ps2[9];
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("m2_up", bus2.p_up, e2_up);    cmp("m2_down", bus2.p_down, e2_dn);
            cmp("m2_left", bus2.p_left, e2_lf); cmp("m2_right", bus2.p_right, e2_rt);
            cmp("m2_fire", bus2.p_fire, e2_fi); cmp("m2_start", bus2.start, e_st);
            cmp("m2_coin", bus2.coin, e_coin);
            cmp("m1_up", bus1.p_up, e1_up);    cmp("m1_down", bus1.p_down, e1_dn);
            cmp("m1_left", bus1.p_left, e1_lf); cmp("m1_right", bus1.p_right, e1_rt);
            cmp("m1_fire", bus1.p_fire, e1_fi); cmp("m1_start", bus1.start, e_st);
            cmp("m1_coin", bus1.coin, e_coin);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic key(input logic pressed, input logic ext, input logic [7:0] code);
        ps2 = {~ps2[10], pressed, ext, code};
    endtask

    typedef struct {
        logic [15:0] j0, j1;
        logic        nr;
        logic [1:0]  up, down, left, right, fire, start;
    } vec_t;

    vec_t vt [9];
    logic [7:0] codes [20];

    initial begin
        vt[0] = '{16'h0008, 16'h0000, 1'b1, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
        vt[1] = '{16'h0008, 16'h0000, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        vt[2] = '{16'h0001, 16'h0000, 1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
        vt[3] = '{16'h0002, 16'h0000, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        vt[4] = '{16'h0004, 16'h0000, 1'b1, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
        vt[5] = '{16'h0000, 16'h0003, 1'b0, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00};
        vt[6] = '{16'h0010, 16'h0010, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00};
        vt[7] = '{16'h0020, 16'h0040, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11};
        vt[8] = '{16'h0000, 16'h0008, 1'b1, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
        codes = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'h14, 8'h05, 8'h16, 8'h06, 8'h1E,
                  8'h2E, 8'h36, 8'h2D, 8'h2B, 8'h23, 8'h34, 8'h1C, 8'h1B, 8'h42, 8'h00};

        ps2 = 11'h400; j0 = 0; j1 = 0; nr = 0; rst_n = 0;

        // 1. reset with toggle high, then release: nothing decoded; up arrow after 2 edges
        tick(3);
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            cmp("idle_up", bus2.p_up, 0);
            cmp("idle_coin", bus2.coin, 0);
            cmp("idle_start", bus2.start, 0);
        end
        ps2 = {1'b0, 1'b1, 1'b1, 8'h75};
        tick(); cmp("key_up_1edge", bus2.p_up, 0);
        tick(); cmp("key_up_2edge", bus2.p_up, 1);
        key(1'b0, 1'b1, 8'h75);
        tick(2); cmp("key_up_release", bus2.p_up, 0);

        // 2. table of joystick/rotation vectors, one edge latency
        for (int i = 0; i < 9; i++) begin
            j0 = vt[i].j0; j1 = vt[i].j1; nr = vt[i].nr;
            tick();
            cmp($sformatf("vec%0d_up", i), bus2.p_up, vt[i].up);
            cmp($sformatf("vec%0d_down", i), bus2.p_down, vt[i].down);
            cmp($sformatf("vec%0d_left", i), bus2.p_left, vt[i].left);
            cmp($sformatf("vec%0d_right", i), bus2.p_right, vt[i].right);
            cmp($sformatf("vec%0d_fire", i), bus2.p_fire, vt[i].fire);
            cmp($sformatf("vec%0d_start", i), bus2.start, vt[i].start);
        end
        j0 = 0; j1 = 0; nr = 0;
        tick(2);

        // 3. coin held 10 cycles -> exactly CP high; no retrigger until release
        j0 = 16'h0080;
        for (int i = 1; i <= 10; i++) begin tick(); cmp("coin_hold", bus2.coin, (i <= CP) ? 1 : 0); end
        j0 = 0;
        for (int i = 0; i < 3; i++) begin tick(); cmp("coin_rel", bus2.coin, 0); end
        j0 = 16'h0080;
        for (int i = 1; i <= 6; i++) begin tick(); cmp("coin_second", bus2.coin, (i <= CP) ? 1 : 0); end
        j0 = 0; tick(3);

        // 4. reset at the second cycle of a pulse, then a full pulse afterwards
        j0 = 16'h0080;
        tick(2); cmp("coin_pre_rst", bus2.coin, 1);
        rst_n = 0; j0 = 0;
        tick(); cmp("coin_rst_drop", bus2.coin, 0);
        rst_n = 1; tick(2);
        j0 = 16'h0080;
        for (int i = 1; i <= 6; i++) begin tick(); cmp("coin_after_rst", bus2.coin, (i <= CP) ? 1 : 0); end
        j0 = 0; tick(3);

        // 5. P2 fire key: to P2 on a 2-player build, folded into P1 on a 1-player build
        key(1'b1, 1'b0, 8'h1C);
        tick(2);
        cmp("p2fire_np2", bus2.p_fire, 2'b10);
        cmp("p2fire_np1", bus1.p_fire, 1);
        key(1'b0, 1'b0, 8'h1C);
        tick(2);
        cmp("p2fire_rel", bus2.p_fire, 0);

`ifdef ARCADE_INPUT_AUTOFIRE_EN
        // 6. autofire square wave and drop
        j0 = 16'h0100;
        for (int i = 1; i <= 12; i++) begin
            tick();
            cmp("autofire", bus2.p_fire[0], ((((i - 1) / AF_DIV) % 2) == 0) ? 1 : 0);
        end
        j0 = 0;
        tick(); cmp("autofire_drop", bus2.p_fire[0], 0);
`endif

        // Randomised traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                int idx;
                logic ext;
                idx = $urandom_range(0, 19);
                ext = (idx < 4) ? 1'($urandom_range(0, 1)) : 1'b0;
                key(1'($urandom_range(0, 1)), ext, codes[idx]);
            end
            if ($urandom_range(0, 7) == 0) j0 = 16'($urandom);
            if ($urandom_range(0, 7) == 0) j1 = 16'($urandom);
            if ($urandom_range(0, 15) == 0) nr = ~nr;
            rst_n = ($urandom_range(0, 299) != 0);
            tick();
        end
        rst_n = 1;
        tick(2);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
